instr_encoder_loader: RTL

- Produces MIPS instruction words and writes them into instruction memory. It is the producer-side counterpart of the pipeline's instruction decoder.
- Accepts one symbolic instruction per handshake (mnemonic code plus fields) and encodes it to the 32-bit MIPS-I word.
- Buffers encoded words in a small FIFO, then writes them sequentially to IMEM from a base address with an ack handshake.
- Used for boot/self-test program loading; loading stops after a SYSCALL word is written.

---
 rtl/instr_encoder_loader_pkg.sv | 172 +++++++++++++++++
 rtl/instr_encoder_loader_word_fifo.sv | 49 ++++
 rtl/instr_encoder_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared mnemonic codes, MIPS-I opcode/funct values and the symbolic-to-word encoder.
// The pipeline decoder imports the same constants, so both sides agree on every field.
package instr_encoder_loader_pkg;

  // Mnemonic codes (41); values 41..63 are illegal
  localparam logic [5:0] MN_ADDU    = 6'd0;
  localparam logic [5:0] MN_SUBU    = 6'd1;
  localparam logic [5:0] MN_AND     = 6'd2;
  localparam logic [5:0] MN_OR      = 6'd3;
  localparam logic [5:0] MN_XOR     = 6'd4;
  localparam logic [5:0] MN_NOR     = 6'd5;
  localparam logic [5:0] MN_SLT     = 6'd6;
  localparam logic [5:0] MN_SLTU    = 6'd7;
  localparam logic [5:0] MN_SLL     = 6'd8;
  localparam logic [5:0] MN_SRL     = 6'd9;
  localparam logic [5:0] MN_SRA     = 6'd10;
  localparam logic [5:0] MN_SLLV    = 6'd11;
  localparam logic [5:0] MN_SRLV    = 6'd12;
  localparam logic [5:0] MN_SRAV    = 6'd13;
  localparam logic [5:0] MN_JR      = 6'd14;
  localparam logic [5:0] MN_JALR    = 6'd15;
  localparam logic [5:0] MN_SYSCALL = 6'd16;
  localparam logic [5:0] MN_ADDI    = 6'd17;
  localparam logic [5:0] MN_ADDIU   = 6'd18;
  localparam logic [5:0] MN_SLTI    = 6'd19;
  localparam logic [5:0] MN_SLTIU   = 6'd20;
  localparam logic [5:0] MN_ANDI    = 6'd21;
  localparam logic [5:0] MN_ORI     = 6'd22;
  localparam logic [5:0] MN_XORI    = 6'd23;
  localparam logic [5:0] MN_LUI     = 6'd24;
  localparam logic [5:0] MN_LB      = 6'd25;
  localparam logic [5:0] MN_LH      = 6'd26;
  localparam logic [5:0] MN_LW      = 6'd27;
  localparam logic [5:0] MN_LBU     = 6'd28;
  localparam logic [5:0] MN_LHU     = 6'd29;
  localparam logic [5:0] MN_SB      = 6'd30;
  localparam logic [5:0] MN_SH      = 6'd31;
  localparam logic [5:0] MN_SW      = 6'd32;
  localparam logic [5:0] MN_BEQ     = 6'd33;
  localparam logic [5:0] MN_BNE     = 6'd34;
  localparam logic [5:0] MN_BLEZ    = 6'd35;
  localparam logic [5:0] MN_BGTZ    = 6'd36;
  localparam logic [5:0] MN_BLTZ    = 6'd37;
  localparam logic [5:0] MN_BGEZ    = 6'd38;
  localparam logic [5:0] MN_J       = 6'd39;
  localparam logic [5:0] MN_JAL     = 6'd40;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic        legal;
    logic        is_sys;
    logic [31:0] word;
  } enc_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OP_SPECIAL, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic enc_t encode(input logic [5:0] mn, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [4:0] sh, input logic [25:0] imm);
    enc_t e;
    e.legal  = 1'b1;
    e.is_sys = 1'b0;
    e.word   = 32'h0;
    case (mn)
      MN_ADDU:    e.word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      MN_SUBU:    e.word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      MN_AND:     e.word = r_word(rs, rt, rd, 5'd0, FN_AND);
      MN_OR:      e.word = r_word(rs, rt, rd, 5'd0, FN_OR);
      MN_XOR:     e.word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      MN_NOR:     e.word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      MN_SLT:     e.word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      MN_SLTU:    e.word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      MN_SLL:     e.word = r_word(5'd0, rt, rd, sh, FN_SLL);
      MN_SRL:     e.word = r_word(5'd0, rt, rd, sh, FN_SRL);
      MN_SRA:     e.word = r_word(5'd0, rt, rd, sh, FN_SRA);
      MN_SLLV:    e.word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      MN_SRLV:    e.word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      MN_SRAV:    e.word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      MN_JR:      e.word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      MN_JALR:    e.word = r_word(rs, 5'd0, rd, 5'd0, FN_JALR);
      MN_SYSCALL: begin
        e.word   = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
        e.is_sys = 1'b1;
      end
      MN_ADDI:    e.word = i_word(OP_ADDI,  rs, rt, imm[15:0]);
      MN_ADDIU:   e.word = i_word(OP_ADDIU, rs, rt, imm[15:0]);
      MN_SLTI:    e.word = i_word(OP_SLTI,  rs, rt, imm[15:0]);
      MN_SLTIU:   e.word = i_word(OP_SLTIU, rs, rt, imm[15:0]);
      MN_ANDI:    e.word = i_word(OP_ANDI,  rs, rt, imm[15:0]);
      MN_ORI:     e.word = i_word(OP_ORI,   rs, rt, imm[15:0]);
      MN_XORI:    e.word = i_word(OP_XORI,  rs, rt, imm[15:0]);
      MN_LUI:     e.word = i_word(OP_LUI,   5'd0, rt, imm[15:0]);
      MN_LB:      e.word = i_word(OP_LB,    rs, rt, imm[15:0]);
      MN_LH:      e.word = i_word(OP_LH,    rs, rt, imm[15:0]);
      MN_LW:      e.word = i_word(OP_LW,    rs, rt, imm[15:0]);
      MN_LBU:     e.word = i_word(OP_LBU,   rs, rt, imm[15:0]);
      MN_LHU:     e.word = i_word(OP_LHU,   rs, rt, imm[15:0]);
      MN_SB:      e.word = i_word(OP_SB,    rs, rt, imm[15:0]);
      MN_SH:      e.word = i_word(OP_SH,    rs, rt, imm[15:0]);
      MN_SW:      e.word = i_word(OP_SW,    rs, rt, imm[15:0]);
      MN_BEQ:     e.word = i_word(OP_BEQ,   rs, rt, imm[15:0]);
      MN_BNE:     e.word = i_word(OP_BNE,   rs, rt, imm[15:0]);
      MN_BLEZ:    e.word = i_word(OP_BLEZ,  rs, 5'd0, imm[15:0]);
      MN_BGTZ:    e.word = i_word(OP_BGTZ,  rs, 5'd0, imm[15:0]);
      // REGIMM branches select the condition through the rt field
      MN_BLTZ:    e.word = i_word(OP_REGIMM, rs, 5'd0, imm[15:0]);
      MN_BGEZ:    e.word = i_word(OP_REGIMM, rs, 5'd1, imm[15:0]);
      MN_J:       e.word = {OP_J, imm};
      MN_JAL:     e.word = {OP_JAL, imm};
      default:    e.legal = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_word_fifo.sv
// Synchronous FIFO holding encoded words plus their syscall tag.
// flush empties it in one cycle; the head entry is readable combinationally.
module instr_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS-I requests, buffers the words and writes them to IMEM
// from BASE_ADDR until a SYSCALL is written or the capacity is reached.
//   state    | meaning
//   ST_IDLE  | FIFO empty, waiting for an encoded word
//   ST_WRITE | imem_we held with FIFO head until imem_ack
//   ST_DONE  | loading finished; requests refused, FIFO discarded
module instr_encoder_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [25:0] req_imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ack,
  output logic [15:0] words_written,
  output logic        done,
  output logic        err_illegal,
  output logic        err_full
);
  import instr_encoder_loader_pkg::*;

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [15:0] CAP      = 16'(IMEM_WORDS);

  wr_state_e   state;
  enc_t        enc;
  logic        accept;
  logic        push;
  logic        pop;
  logic [32:0] head;
  logic        head_sys;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] count;
  logic [AW:0] next_count;
  logic        at_capacity;

  assign enc         = encode(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm);
  assign accept      = req_valid && req_ready;
  assign push        = accept && enc.legal;
  assign pop         = (state == ST_WRITE) && imem_ack;
  assign head_sys    = head[32];
  assign imem_wdata  = head[31:0];
  assign next_count  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign at_capacity = (words_written + 16'd1) == CAP;

  instr_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (state == ST_DONE),
    .push      (push),
    .push_data ({enc.is_sys, enc.word}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      imem_we       <= 1'b0;
      imem_addr     <= BASE_ADDR;
      words_written <= 16'd0;
      done          <= 1'b0;
      err_illegal   <= 1'b0;
      err_full      <= 1'b0;
      req_ready     <= 1'b1;
    end else begin
      if (accept && !enc.legal) err_illegal <= 1'b1;
      // Ready is precomputed from next occupancy so it never depends on imem_ack combinationally
      req_ready <= (next_count != FULL_CNT) && !done;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty || push) begin
            state   <= ST_WRITE;
            imem_we <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (imem_ack) begin
            imem_addr     <= imem_addr + 32'd4;
            words_written <= words_written + 16'd1;
            if (head_sys || at_capacity) begin
              state     <= ST_DONE;
              imem_we   <= 1'b0;
              done      <= 1'b1;
              req_ready <= 1'b0;
              if (!head_sys) err_full <= 1'b1;
            end else if (count != ONE_CNT || push) begin
              imem_we <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              imem_we <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          imem_we   <= 1'b0;
          req_ready <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          imem_we <= 1'b0;
        end
      endcase
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
